// File: rtl/uart_frame_tx_if.sv
// Word handshake into the UART frame transmitter: master offers tx_data/tx_valid,
// slave answers with tx_ready.
interface uart_frame_tx_if #(
    parameter int unsigned MSG_BITS = 8
) ();
    logic [MSG_BITS-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: FIFO-buffered words sent as start, LSB-first data, stop.
// Optional macro UART_TX_GUARD_EN adds GUARD_BITS of extra idle-high line after each stop bit.
module uart_frame_tx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 38400,
    parameter int unsigned DIV_SAMPLE = 8,
    parameter int unsigned MSG_BITS   = 8,  // MESSAGE_SIZE of the paired receiver
    parameter int unsigned FIFO_DEPTH = 4
`ifdef UART_TX_GUARD_EN
    ,
    parameter int unsigned GUARD_BITS = 1
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_frame_tx_if.slave              tx,
    output logic                        TxD,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    // Same integer-division order as the receiver so both ends agree on the bit period.
    localparam int unsigned BIT_CYCLES = (CLK_FREQ / (BAUD_RATE * DIV_SAMPLE)) * DIV_SAMPLE;
    localparam int unsigned CycW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned PtrW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW       = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
`ifdef UART_TX_GUARD_EN
        ,
        StGuard
`endif
    } state_e;

    state_e              state_q, state_d;
    logic [CycW-1:0]     cyc_q, cyc_d;
    logic [3:0]          bit_q, bit_d;
    logic [MSG_BITS-1:0] sh_q, sh_d;
    logic                txd_q, txd_d;
    logic                tail_q;
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q, count_d;
    logic [MSG_BITS-1:0] mem_q [FIFO_DEPTH];
    logic                push, pop, end_bit, frame_done;

    assign tx.tx_ready = (count_q != CntW'(FIFO_DEPTH));
    assign push        = tx.tx_valid && tx.tx_ready;
    assign end_bit     = (cyc_q == CycW'(BIT_CYCLES - 1));
    assign count_d     = count_q + CntW'(push) - CntW'(pop);
    assign TxD         = txd_q;
    assign fifo_count  = count_q;
    // tail_q covers the final stop-bit clock, since TxD trails the state by one edge.
    assign busy        = (state_q != StIdle) || (count_q != '0) || tail_q;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        pop        = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rd_ptr_q];
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (end_bit) begin
                    cyc_d   = '0;
                    state_d = StData;
                end else cyc_d = cyc_q + 1'b1;
            end
            StData: begin
                if (end_bit) begin
                    cyc_d = '0;
                    sh_d  = sh_q >> 1;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 4'(MSG_BITS - 1)) state_d = StStop;
                end else cyc_d = cyc_q + 1'b1;
            end
            StStop: begin
                if (end_bit) begin
                    cyc_d = '0;
`ifdef UART_TX_GUARD_EN
                    bit_d   = '0;
                    state_d = StGuard;
`else
                    frame_done = 1'b1;
`endif
                end else cyc_d = cyc_q + 1'b1;
            end
`ifdef UART_TX_GUARD_EN
            StGuard: begin
                if (end_bit) begin
                    cyc_d = '0;
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 4'(GUARD_BITS - 1)) frame_done = 1'b1;
                end else cyc_d = cyc_q + 1'b1;
            end
`endif
            default: state_d = StIdle;
        endcase
        // Chain straight into the next start bit when a word is waiting.
        if (frame_done) begin
            if (count_q != '0) begin
                pop     = 1'b1;
                sh_d    = mem_q[rd_ptr_q];
                bit_d   = '0;
                state_d = StStart;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            StStart: txd_d = 1'b0;
            StData:  txd_d = sh_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cyc_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            txd_q    <= 1'b1;
            tail_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            txd_q    <= txd_d;
            tail_q   <= (state_q != StIdle);
            count_q  <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= tx.tx_data;
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx with a 16-clock bit period; honours UART_TX_GUARD_EN
// with GUARD_BITS=2.
module tb_uart_frame_tx;
    // (100 / (6*8)) * 8 = 2 * 8 = 16 clocks per bit
    localparam int unsigned BC = 16;
`ifdef UART_TX_GUARD_EN
    localparam int unsigned GAP = 2 * BC;
`else
    localparam int unsigned GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       TxD;
    logic       busy;
    logic [2:0] fifo_count;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] w [6];

    uart_frame_tx_if #(.MSG_BITS(8)) txif ();

    uart_frame_tx #(
        .CLK_FREQ  (100),
        .BAUD_RATE (6),
        .DIV_SAMPLE(8),
        .MSG_BITS  (8),
        .FIFO_DEPTH(4)
`ifdef UART_TX_GUARD_EN
        ,
        .GUARD_BITS(2)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx        (txif.slave),
        .TxD       (TxD),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk);
        txif.tx_data  = d;
        txif.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        txif.tx_valid = 1'b0;
    endtask

    task automatic wait_fall(output int n);
        n = 0;
        while (TxD !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
    endtask

    // Starts on the first sample of the start bit; returns on the first sample after the stop bit.
    task automatic get_frame(output logic [7:0] d, output int bad, output logic busy_last);
        logic v;
        bad = 0;
        d = '0;
        busy_last = 1'b0;
        for (int b = 0; b < 10; b++) begin
            v = TxD;
            if (b == 0 && v !== 1'b0) bad++;
            if (b == 9 && v !== 1'b1) bad++;
            if (b >= 1 && b <= 8) d[b-1] = v;
            for (int c = 0; c < int'(BC); c++) begin
                if (TxD !== v) bad++;
                busy_last = busy;
                tick();
            end
        end
    endtask

    initial begin
        int         n;
        int         bad;
        logic [7:0] d;
        logic       bl;
        logic [7:0] r;

        w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        txif.tx_valid = 1'b0;
        txif.tx_data  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", 32'(TxD), 1);
        check("rst_ready", 32'(txif.tx_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(fifo_count), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single frame
        push(8'hA5);
        check("single_busy_rise", 32'(busy), 1);
        check("single_count", 32'(fifo_count), 1);
        wait_fall(n);
        check("single_latency", 32'(n), 2);
        get_frame(d, bad, bl);
        check("single_data", 32'(d), 32'hA5);
        check("single_bits", 32'(bad), 0);
        check("single_busy_last", 32'(bl), 1);
        repeat (GAP) tick();
        check("single_busy_fall", 32'(busy), 0);

        // Back-to-back
        @(negedge clk);
        txif.tx_data  = 8'h01;
        txif.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        txif.tx_data = 8'hFF;
        @(posedge clk);
        #1;
        txif.tx_valid = 1'b0;
        wait_fall(n);
        check("b2b_latency", 32'(n), 1);
        get_frame(d, bad, bl);
        check("b2b_data0", 32'(d), 32'h01);
        check("b2b_bits0", 32'(bad), 0);
        n = 0;
        while (TxD === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check("b2b_gap", 32'(n), GAP);
        get_frame(d, bad, bl);
        check("b2b_data1", 32'(d), 32'hFF);
        check("b2b_bits1", 32'(bad), 0);
        check("b2b_busy_last", 32'(bl), 1);
        repeat (GAP) tick();
        check("b2b_busy_fall", 32'(busy), 0);

        // FIFO full: valid held high over six words
        fork
            begin : pusher
                int   idx = 0;
                int   t = 0;
                int   drop = -1;
                int   t6 = -1;
                int   cnt_drop = -1;
                logic acc;
                while (idx < 6 && t < 3000) begin
                    @(negedge clk);
                    txif.tx_data  = w[idx];
                    txif.tx_valid = 1'b1;
                    acc = txif.tx_ready;
                    if (!acc && drop < 0) begin
                        drop = idx;
                        cnt_drop = int'(fifo_count);
                    end
                    @(posedge clk);
                    if (acc) begin
                        if (idx == 5) t6 = t;
                        idx++;
                    end
                    t++;
                end
                #1;
                txif.tx_valid = 1'b0;
                check("full_drop_after", 32'(drop), 5);
                check("full_count_at_drop", 32'(cnt_drop), 4);
                check("full_sixth_edge", 32'(t6), 2 + 10 * BC + GAP);
            end
            begin : decoder
                int         m;
                int         bb;
                logic [7:0] dd;
                logic       bz;
                for (int k = 0; k < 6; k++) begin
                    wait_fall(m);
                    get_frame(dd, bb, bz);
                    check("full_data", 32'(dd), 32'(w[k]));
                    check("full_bits", 32'(bb), 0);
                end
            end
        join
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check("full_drain", 32'(busy), 0);

        // Reset during data bit 3 of 8'h3C with two words queued
        push(8'h3C);
        push(8'hAA);
        push(8'h55);
        wait_fall(n);
        check("rstmid_latency_left", 32'(n), 0);
        repeat (4 * BC + BC / 2) tick();
        check("rstmid_count_before", 32'(fifo_count), 2);
        check("rstmid_bit3", 32'(TxD), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_txd", 32'(TxD), 1);
        check("rstmid_count", 32'(fifo_count), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_ready", 32'(txif.tx_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < int'(12 * BC); i++) begin
            tick();
            if (TxD !== 1'b1 || busy !== 1'b0) n++;
        end
        check("rstmid_silent", 32'(n), 0);

        // Loopback of random words through the bench's frame decoder
        for (int i = 0; i < 16; i++) begin
            r = 8'($urandom);
            push(r);
            wait_fall(n);
            check("lb_latency", 32'(n), 2);
            get_frame(d, bad, bl);
            check("lb_data", 32'(d), 32'(r));
            check("lb_bits", 32'(bad), 0);
            repeat (GAP) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
